// File: rtl/rdma_sq_pkg.sv
`default_nettype none
// ============================================================================
// rdma_sq_pkg : request/ack record layouts, opcodes and FSM encodings shared
//               by the RDMA send-queue responder.
// Revision    : 1.0
// ============================================================================
package rdma_sq_pkg;

  localparam int REQ_BITS = 144;
  localparam int ACK_BITS = 16;

  localparam logic [4:0] OP_WRITE = 5'd1;
  localparam logic [4:0] OP_SEND  = 5'd2;

  typedef struct packed {
    logic        last;
    logic [31:0] len;
    logic [47:0] vaddr_remote;
    logic [47:0] vaddr_local;
    logic [9:0]  qpn;
    logic [4:0]  opcode;
  } req_t;

  typedef struct packed {
    logic       err;
    logic [9:0] qpn;
    logic [4:0] opcode;
  } ack_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  function automatic logic [31:0] chunk_len(input logic [31:0] remaining,
                                            input logic [31:0] pmtu);
    return (remaining < pmtu) ? remaining : pmtu;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rdma_axis_skid.sv
`default_nettype none
// ============================================================================
// rdma_axis_skid : 2-entry AXI4-Stream skid buffer (tdata/tkeep/tlast),
//                  full throughput, ready drops only when both entries are held.
// Revision       : 1.0
// ============================================================================
module rdma_axis_skid #(
  parameter int DATA_BITS = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_BITS-1:0]   s_tdata_i,
  input  logic [DATA_BITS/8-1:0] s_tkeep_i,
  input  logic                   s_tlast_i,
  input  logic                   s_tvalid_i,
  output logic                   s_tready_o,
  output logic [DATA_BITS-1:0]   m_tdata_o,
  output logic [DATA_BITS/8-1:0] m_tkeep_o,
  output logic                   m_tlast_o,
  output logic                   m_tvalid_o,
  input  logic                   m_tready_i
);

  localparam int W = DATA_BITS + DATA_BITS / 8 + 1;

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         w_push;
  logic         w_pop;

  assign s_tready_o = (count_q != 2'd2) && !rst;
  assign m_tvalid_o = (count_q != 2'd0);
  assign w_push     = s_tvalid_i && s_tready_o;
  assign w_pop      = m_tvalid_o && m_tready_i;
  assign {m_tdata_o, m_tkeep_o, m_tlast_o} = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {s_tdata_i, s_tkeep_i, s_tlast_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_push) wr_ptr_q <= ~wr_ptr_q;
      if (w_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/rdma_sq_responder.sv
`default_nettype none
// ============================================================================
// rdma_sq_responder : splits SQ work requests into PMTU-sized rd_req chunks,
//                     forwards payload to network TX and posts one ack each.
// Revision          : 1.0
// ============================================================================
module rdma_sq_responder
  import rdma_sq_pkg::*;
#(
  parameter int PMTU_BYTES      = 4096,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DATA_BITS       = 512
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_sq_valid,
  output logic                   s_sq_ready,
  input  logic [REQ_BITS-1:0]    s_sq_data,
  output logic                   m_rd_req_valid,
  input  logic                   m_rd_req_ready,
  output logic [REQ_BITS-1:0]    m_rd_req_data,
  input  logic [DATA_BITS-1:0]   s_axis_data_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_data_tkeep,
  input  logic                   s_axis_data_tlast,
  input  logic                   s_axis_data_tvalid,
  output logic                   s_axis_data_tready,
  output logic [DATA_BITS-1:0]   m_axis_net_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_net_tkeep,
  output logic                   m_axis_net_tlast,
  output logic                   m_axis_net_tvalid,
  input  logic                   m_axis_net_tready,
  output logic                   m_ack_valid,
  input  logic                   m_ack_ready,
  output logic [ACK_BITS-1:0]    m_ack_data
);

  localparam int          OW     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] C_PMTU = 32'(PMTU_BYTES);
  localparam logic [OW-1:0] C_MAX = OW'(MAX_OUTSTANDING);

  logic [1:0]    state_q, state_d;
  req_t          cur_q, cur_d;   // cur.len tracks the bytes still to be issued
  logic          err_q, err_d;
  logic [OW-1:0] out_q, out_d;

  req_t        w_sq_req;
  req_t        w_rd_req;
  ack_t        w_ack;
  logic [31:0] w_clen;
  logic        w_last;
  logic        w_sq_hs;
  logic        w_rd_hs;
  logic        w_net_last_hs;
  logic        w_op_ok;

  assign w_sq_req      = req_t'(s_sq_data);
  assign w_clen        = chunk_len(cur_q.len, C_PMTU);
  assign w_last        = (cur_q.len == w_clen);
  assign w_op_ok       = (w_sq_req.opcode == OP_WRITE) || (w_sq_req.opcode == OP_SEND);

  assign s_sq_ready     = (state_q == ST_IDLE) && !areset;
  assign m_rd_req_valid = (state_q == ST_ISSUE) && (out_q < C_MAX);
  assign m_ack_valid    = (state_q == ST_ACK);
  assign w_sq_hs        = s_sq_valid && s_sq_ready;
  assign w_rd_hs        = m_rd_req_valid && m_rd_req_ready;
  assign w_net_last_hs  = m_axis_net_tvalid && m_axis_net_tready && m_axis_net_tlast;

  always_comb begin
    w_rd_req              = cur_q;
    w_rd_req.last         = w_last;
    w_rd_req.len          = w_clen;
    w_ack.err             = err_q;
    w_ack.qpn             = cur_q.qpn;
    w_ack.opcode          = cur_q.opcode;
  end

  assign m_rd_req_data = w_rd_req;
  assign m_ack_data    = w_ack;

  always_comb begin
    out_d = out_q;
    if (w_rd_hs && !w_net_last_hs) begin
      out_d = out_q + OW'(1);
    end else if (!w_rd_hs && w_net_last_hs) begin
      out_d = out_q - OW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (w_sq_hs) begin
          cur_d      = w_sq_req;
          cur_d.last = 1'b0;
          err_d      = !w_op_ok;
          state_d    = (!w_op_ok || w_sq_req.len == 32'd0) ? ST_ACK : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_rd_hs) begin
          cur_d.len          = cur_q.len - w_clen;
          cur_d.vaddr_local  = cur_q.vaddr_local + 48'(w_clen);
          cur_d.vaddr_remote = cur_q.vaddr_remote + 48'(w_clen);
          if (w_last) state_d = ST_DRAIN;
        end
      end
      // Looking at the next count lets the ack follow the final tlast by one cycle.
      ST_DRAIN: begin
        if (out_d == '0) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (m_ack_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset && w_net_last_hs && !w_rd_hs) begin
      assert (out_q != '0);
    end
  end

  rdma_axis_skid #(
    .DATA_BITS (DATA_BITS)
  ) u_skid (
    .clk        (aclk),
    .rst        (areset),
    .s_tdata_i  (s_axis_data_tdata),
    .s_tkeep_i  (s_axis_data_tkeep),
    .s_tlast_i  (s_axis_data_tlast),
    .s_tvalid_i (s_axis_data_tvalid),
    .s_tready_o (s_axis_data_tready),
    .m_tdata_o  (m_axis_net_tdata),
    .m_tkeep_o  (m_axis_net_tkeep),
    .m_tlast_o  (m_axis_net_tlast),
    .m_tvalid_o (m_axis_net_tvalid),
    .m_tready_i (m_axis_net_tready)
  );

endmodule
`default_nettype wire
